pipeline_flow_controller: RTL

PIPELINE_FLOW_CONTROLLER -- requirements
Module: pipeline_flow_controller

---
 rtl/pipeline_flow_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_flow_controller.sv
// Frame sequencer for a linearizer -> estimator -> delinearizer pipeline.
// Issues per-stage start strobes, collects acks, and times out any stage that stalls.
module pipeline_flow_controller #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CONT    = 0
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           go,
    input  logic           abort,
    input  logic [NCH-1:0] ack_lin,
    input  logic           ack_est,
    input  logic [NCH-1:0] ack_out,
    output logic [NCH-1:0] start_lin,
    output logic           start_est,
    output logic [NCH-1:0] start_out,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [1:0]     err_stage,
    output logic [15:0]    frames
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIN,
        S_EST,
        S_OUT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] TMO_VAL = 16'(TIMEOUT);
    localparam bit          CONT_EN = (CONT != 0);

    state_t         state;
    logic [15:0]    stg_cnt;
    logic [NCH-1:0] lin_cmp;
    logic [NCH-1:0] out_cmp;

    logic [NCH-1:0] lin_set;
    logic [NCH-1:0] out_set;
    logic           lin_last;
    logic           est_last;
    logic           out_last;
    logic           tmo;

    // A channel only counts as finished when its ack lands while its start is still high.
    assign lin_set  = lin_cmp | (start_lin & ack_lin);
    assign out_set  = out_cmp | (start_out & ack_out);
    assign lin_last = &lin_set;
    assign est_last = start_est & ack_est;
    assign out_last = &out_set;
    assign tmo      = (stg_cnt == TMO_VAL);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            stg_cnt   <= '0;
            lin_cmp   <= '0;
            out_cmp   <= '0;
            start_lin <= '0;
            start_est <= 1'b0;
            start_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_stage <= 2'd0;
            frames    <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            stg_cnt   <= '0;
            lin_cmp   <= '0;
            out_cmp   <= '0;
            start_lin <= '0;
            start_est <= 1'b0;
            start_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_stage <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_LIN;
                        start_lin <= '1;
                        lin_cmp   <= '0;
                        stg_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_LIN: begin
                    start_lin <= start_lin & ~ack_lin;
                    lin_cmp   <= lin_set;
                    stg_cnt   <= stg_cnt + 16'd1;
                    // Completion is checked first so a late ack still beats the timeout.
                    if (lin_last) begin
                        state     <= S_EST;
                        start_est <= 1'b1;
                        stg_cnt   <= '0;
                    end else if (tmo) begin
                        state     <= S_ERR;
                        start_lin <= '0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_stage <= 2'd1;
                    end
                end
                S_EST: begin
                    stg_cnt <= stg_cnt + 16'd1;
                    if (est_last) begin
                        state     <= S_OUT;
                        start_est <= 1'b0;
                        start_out <= '1;
                        out_cmp   <= '0;
                        stg_cnt   <= '0;
                    end else if (tmo) begin
                        state     <= S_ERR;
                        start_est <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_stage <= 2'd2;
                    end
                end
                S_OUT: begin
                    start_out <= start_out & ~ack_out;
                    out_cmp   <= out_set;
                    stg_cnt   <= stg_cnt + 16'd1;
                    if (out_last) begin
                        state   <= S_DONE;
                        stg_cnt <= '0;
                        busy    <= 1'b0;
                    end else if (tmo) begin
                        state     <= S_ERR;
                        start_out <= '0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_stage <= 2'd3;
                    end
                end
                S_DONE: begin
                    done   <= 1'b1;
                    frames <= frames + 16'd1;
                    if (CONT_EN && go) begin
                        state     <= S_LIN;
                        start_lin <= '1;
                        lin_cmp   <= '0;
                        stg_cnt   <= '0;
                        busy      <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    // Parked until abort; abort is handled above.
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
